// File: rtl/memory_stage_if.sv
// Data-cache port of the memory stage: request/response bundle between the
// pipeline (master) and the data cache (slave).
interface memory_stage_if #(
    parameter int WORD_W = 32
);
    // Handshake: the master raises dmemREN or dmemWEN and holds it together
    // with dmemaddr/dmemstore unchanged until the slave answers with dhit;
    // the request and dhit are both high in the completing cycle, and for a
    // read dmemload is valid in that cycle only.
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/memory_stage.sv
// EX/MEM latch plus memory-access stage: holds the execute result, runs the
// data-cache handshake, stalls until dhit and registers writeback data.
module memory_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int SEL_W  = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              flush,
    input  logic [WORD_W-1:0] nPC_next,
    input  logic              dREN_next,
    input  logic              dWEN_next,
    input  logic              regWr_next,
    input  logic [SEL_W-1:0]  regSel_next,
    input  logic [REG_W-1:0]  regDst_next,
    input  logic [WORD_W-1:0] ALUOut_next,
    input  logic [WORD_W-1:0] storeData_next,
    input  logic              halt_next,
    memory_stage_if.master    dmem,
    output logic              mem_stall,
    output logic              regWr_wb,
    output logic [REG_W-1:0]  regDst_wb,
    output logic [WORD_W-1:0] wdat_wb,
    output logic              halt_wb,
    output logic              exmem_regWr,
    output logic [REG_W-1:0]  exmem_regDst,
    output logic [WORD_W-1:0] exmem_ALUOut,
    output logic [1:0]        dbg_state
);
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbit_t;
    typedef logic [SEL_W-1:0]  regsel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t  state;
    word_t   ex_npc;
    logic    ex_dren;
    logic    ex_dwen;
    logic    ex_regwr;
    regsel_t ex_regsel;
    regbit_t ex_regdst;
    word_t   ex_aluout;
    word_t   ex_store;
    logic    ex_halt;
    word_t   load_buf;
    word_t   wb_data;
    logic    memop;
    logic    mem_ready;
    logic    advance;

    assign memop     = ex_dren | ex_dwen;
    assign mem_ready = !memop || (state == DONE) || ((state == WAIT) && dmem.dhit);
    assign advance   = ihit && mem_ready;
    assign mem_stall = memop && !mem_ready;

    // The request is decoded from registers only, so it drops as soon as
    // reset clears the latch and never glitches with dhit.
    assign dmem.dmemREN   = ex_dren && (state == WAIT);
    assign dmem.dmemWEN   = ex_dwen && (state == WAIT);
    assign dmem.dmemaddr  = ex_aluout;
    assign dmem.dmemstore = ex_store;

    assign exmem_regWr  = ex_regwr;
    assign exmem_regDst = ex_regdst;
    assign exmem_ALUOut = ex_aluout;
    assign dbg_state    = state;

    // Load data comes straight from the cache when the hit and the advance
    // coincide; otherwise it was parked in load_buf by the WAIT->DONE step.
    always_comb begin
        wb_data = ex_aluout;
        case (ex_regsel)
            SEL_W'(1): wb_data = (state == WAIT) ? dmem.dmemload : load_buf;
            SEL_W'(2): wb_data = ex_npc;
            default:   wb_data = ex_aluout;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ex_npc    <= '0;
            ex_dren   <= 1'b0;
            ex_dwen   <= 1'b0;
            ex_regwr  <= 1'b0;
            ex_regsel <= '0;
            ex_regdst <= '0;
            ex_aluout <= '0;
            ex_store  <= '0;
            ex_halt   <= 1'b0;
            load_buf  <= '0;
            regWr_wb  <= 1'b0;
            regDst_wb <= '0;
            wdat_wb   <= '0;
            halt_wb   <= 1'b0;
        end else begin
            if (advance) begin
                if (flush) begin
                    ex_npc    <= '0;
                    ex_dren   <= 1'b0;
                    ex_dwen   <= 1'b0;
                    ex_regwr  <= 1'b0;
                    ex_regsel <= '0;
                    ex_regdst <= '0;
                    ex_aluout <= '0;
                    ex_store  <= '0;
                    ex_halt   <= 1'b0;
                    state     <= IDLE;
                end else begin
                    ex_npc    <= nPC_next;
                    ex_dren   <= dREN_next;
                    ex_dwen   <= dWEN_next;
                    ex_regwr  <= regWr_next;
                    ex_regsel <= regSel_next;
                    ex_regdst <= regDst_next;
                    ex_aluout <= ALUOut_next;
                    ex_store  <= storeData_next;
                    ex_halt   <= halt_next;
                    state     <= (dREN_next || dWEN_next) ? WAIT : IDLE;
                end
                regWr_wb  <= ex_regwr;
                regDst_wb <= ex_regdst;
                wdat_wb   <= wb_data;
                halt_wb   <= halt_wb || ex_halt;
            end else begin
                if ((state == WAIT) && dmem.dhit) begin
                    state    <= DONE;
                    load_buf <= dmem.dmemload;
                end
                // A stalled cycle hands writeback a bubble so the stuck
                // instruction is not written back twice.
                if (ihit) begin
                    regWr_wb <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: program-order reference model feeds a
// writeback scoreboard and a cache-request scoreboard.
module tb_memory_stage;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int SEL_W  = 2;
  localparam int EXP_W  = 3 + REG_W + 2 * WORD_W;
  localparam int MEM_W  = 1 + 2 * WORD_W;
  localparam int N_RAND = 3000;

  logic              CLK;
  logic              nRST;
  logic              ihit;
  logic              flush;
  logic [WORD_W-1:0] nPC_next;
  logic              dREN_next;
  logic              dWEN_next;
  logic              regWr_next;
  logic [SEL_W-1:0]  regSel_next;
  logic [REG_W-1:0]  regDst_next;
  logic [WORD_W-1:0] ALUOut_next;
  logic [WORD_W-1:0] storeData_next;
  logic              halt_next;
  logic              mem_stall;
  logic              regWr_wb;
  logic [REG_W-1:0]  regDst_wb;
  logic [WORD_W-1:0] wdat_wb;
  logic              halt_wb;
  logic              exmem_regWr;
  logic [REG_W-1:0]  exmem_regDst;
  logic [WORD_W-1:0] exmem_ALUOut;
  logic [1:0]        dbg_state;

  memory_stage_if #(.WORD_W(WORD_W)) mif ();

  memory_stage #(.WORD_W(WORD_W), .REG_W(REG_W), .SEL_W(SEL_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
    .nPC_next(nPC_next), .dREN_next(dREN_next), .dWEN_next(dWEN_next),
    .regWr_next(regWr_next), .regSel_next(regSel_next), .regDst_next(regDst_next),
    .ALUOut_next(ALUOut_next), .storeData_next(storeData_next), .halt_next(halt_next),
    .dmem(mif), .mem_stall(mem_stall), .regWr_wb(regWr_wb), .regDst_wb(regDst_wb),
    .wdat_wb(wdat_wb), .halt_wb(halt_wb), .exmem_regWr(exmem_regWr),
    .exmem_regDst(exmem_regDst), .exmem_ALUOut(exmem_ALUOut), .dbg_state(dbg_state)
  );

  // entry: {memop, halt, regwr, regdst, wdat, aluout}; one per EX/MEM occupant
  logic [EXP_W-1:0]  exp_q[$];
  // cache op: {is_store, addr, store data}
  logic [MEM_W-1:0]  mem_q[$];
  logic [WORD_W-1:0] ref_mem[0:7];
  logic [WORD_W-1:0] cache_mem[0:7];
  logic              model_halt;
  bit                resp_en;
  bit                mon_en;
  int                n_cmp;
  int                n_err;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One EX-stage slot; the model accepts it when the pipeline advances.
  task automatic drive_cycle(input bit rnd);
    int                kind;
    int                sel;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wd;
    logic [EXP_W-1:0]  e;
    @(negedge CLK);
    ihit           = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
    flush          = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
    kind           = rnd ? $urandom_range(0, 2) : 0;
    addr           = WORD_W'($urandom_range(0, 7)) << 2;
    nPC_next       = WORD_W'($urandom) & ~WORD_W'(3);
    storeData_next = WORD_W'($urandom);
    regDst_next    = REG_W'($urandom_range(0, 31));
    halt_next      = rnd && ($urandom_range(0, 63) == 0);
    dREN_next      = (kind == 1);
    dWEN_next      = (kind == 2);
    case (kind)
      1: begin regWr_next = 1'b1; regSel_next = SEL_W'(1); ALUOut_next = addr; end
      2: begin regWr_next = 1'b0; regSel_next = SEL_W'(0); ALUOut_next = addr; end
      default: begin
        sel         = $urandom_range(0, 2);
        regWr_next  = 1'($urandom_range(0, 1));
        regSel_next = (sel == 0) ? SEL_W'(0) : SEL_W'(sel + 1);
        ALUOut_next = WORD_W'($urandom);
      end
    endcase
    #1;
    if (ihit && !mem_stall) begin
      if (flush) begin
        e = '0;
      end else begin
        if (kind == 1) wd = ref_mem[addr[4:2]];
        else if (regSel_next == SEL_W'(2)) wd = nPC_next;
        else wd = ALUOut_next;
        if (kind == 2) ref_mem[addr[4:2]] = storeData_next;
        e = {kind != 0, halt_next, regWr_next, regDst_next, wd, ALUOut_next};
        if (kind != 0) mem_q.push_back({kind == 2, ALUOut_next, storeData_next});
      end
      exp_q.push_back(e);
    end
  endtask

  // Data cache: random hit latency, spurious dhit when nothing is requested.
  always begin : responder
    logic [MEM_W-1:0] m;
    @(negedge CLK);
    if (resp_en && (mif.dmemREN || mif.dmemWEN)) begin
      if (mem_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL cache_req: unexpected request addr %h", mif.dmemaddr);
        mif.dhit = 1'b0;
      end else begin
        m = mem_q[0];
        check("req_kind", WORD_W'({mif.dmemWEN, mif.dmemREN}), m[2*WORD_W] ? 32'd2 : 32'd1);
        check("req_addr", mif.dmemaddr, m[2*WORD_W-1:WORD_W]);
        if (m[2*WORD_W]) check("req_store", mif.dmemstore, m[WORD_W-1:0]);
        mif.dhit = ($urandom_range(0, 2) == 0);
        if (mif.dhit) begin
          if (m[2*WORD_W]) cache_mem[m[WORD_W+4:WORD_W+2]] = m[WORD_W-1:0];
          else mif.dmemload = cache_mem[m[WORD_W+4:WORD_W+2]];
          void'(mem_q.pop_front());
        end else begin
          mif.dmemload = WORD_W'($urandom);
        end
      end
    end else begin
      mif.dhit     = resp_en && ($urandom_range(0, 9) == 0);
      mif.dmemload = WORD_W'($urandom);
    end
  end

  always begin : monitor
    bit               retire;
    bit               bub;
    logic [EXP_W-1:0] e;
    @(negedge CLK);
    #2;
    retire = mon_en && ihit && !mem_stall;
    bub    = mon_en && ihit && mem_stall;
    if (mon_en && exp_q.size() > 0 && !exp_q[0][EXP_W-1])
      check("no_stall_non_mem", WORD_W'(mem_stall), 32'd0);
    @(posedge CLK);
    #1;
    if (retire) begin
      if (exp_q.size() < 2) begin
        n_cmp++; n_err++;
        $display("FAIL wb_retire: scoreboard holds %0d entries, needs 2", exp_q.size());
      end else begin
        e = exp_q.pop_front();
        model_halt = model_halt | e[EXP_W-2];
        check("regWr_wb", WORD_W'(regWr_wb), WORD_W'(e[EXP_W-3]));
        check("halt_wb", WORD_W'(halt_wb), WORD_W'(model_halt));
        if (e[EXP_W-3]) begin
          check("regDst_wb", WORD_W'(regDst_wb), WORD_W'(e[2*WORD_W +: REG_W]));
          check("wdat_wb", wdat_wb, e[2*WORD_W-1:WORD_W]);
        end
        e = exp_q[0];
        check("exmem_regWr", WORD_W'(exmem_regWr), WORD_W'(e[EXP_W-3]));
        check("exmem_regDst", WORD_W'(exmem_regDst), WORD_W'(e[2*WORD_W +: REG_W]));
        check("exmem_ALUOut", exmem_ALUOut, e[WORD_W-1:0]);
      end
    end
    if (bub) begin
      check("stall_bubble_regWr", WORD_W'(regWr_wb), 32'd0);
      check("stall_bubble_halt", WORD_W'(halt_wb), WORD_W'(model_halt));
    end
  end

  initial begin
    nRST = 1'b0; ihit = 1'b0; flush = 1'b0; nPC_next = '0;
    dREN_next = 1'b0; dWEN_next = 1'b0; regWr_next = 1'b0; regSel_next = '0;
    regDst_next = '0; ALUOut_next = '0; storeData_next = '0; halt_next = 1'b0;
    mif.dhit = 1'b0; mif.dmemload = '0;
    resp_en = 0; mon_en = 0; model_halt = 1'b0; n_cmp = 0; n_err = 0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i]   = WORD_W'($urandom);
      cache_mem[i] = ref_mem[i];
    end
    repeat (2) @(posedge CLK);
    #1;
    check("rst_regWr_wb", WORD_W'(regWr_wb), 32'd0);
    check("rst_wdat_wb", wdat_wb, 32'd0);
    check("rst_exmem_ALUOut", exmem_ALUOut, 32'd0);
    check("rst_dmemREN", WORD_W'(mif.dmemREN), 32'd0);
    check("rst_state", WORD_W'(dbg_state), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    exp_q.push_back('0);
    resp_en = 1;
    mon_en  = 1;
    repeat (N_RAND) drive_cycle(1'b1);
    repeat (40) drive_cycle(1'b0);
    resp_en  = 0;
    mon_en   = 0;
    mif.dhit = 1'b0;

    // Reset while a load is waiting on the cache.
    @(negedge CLK);
    ihit = 1'b1; flush = 1'b0; dREN_next = 1'b1; dWEN_next = 1'b0;
    regWr_next = 1'b1; regSel_next = SEL_W'(1); ALUOut_next = 32'h0000_0040;
    @(posedge CLK);
    #1;
    dREN_next = 1'b0;
    check("lw_dmemREN", WORD_W'(mif.dmemREN), 32'd1);
    check("lw_dmemaddr", mif.dmemaddr, 32'h0000_0040);
    check("lw_state_wait", WORD_W'(dbg_state), 32'd1);
    repeat (2) begin
      @(negedge CLK);
      #1;
      check("lw_mem_stall", WORD_W'(mem_stall), 32'd1);
      check("lw_req_held", mif.dmemaddr, 32'h0000_0040);
    end
    nRST = 1'b0;
    #1;
    check("rst_mid_dmemREN", WORD_W'(mif.dmemREN), 32'd0);
    check("rst_mid_mem_stall", WORD_W'(mem_stall), 32'd0);
    check("rst_mid_regWr_wb", WORD_W'(regWr_wb), 32'd0);
    check("rst_mid_wdat_wb", wdat_wb, 32'd0);
    check("rst_mid_halt_wb", WORD_W'(halt_wb), 32'd0);
    check("rst_mid_exmem_regWr", WORD_W'(exmem_regWr), 32'd0);
    check("rst_mid_exmem_ALUOut", exmem_ALUOut, 32'd0);
    check("rst_mid_state", WORD_W'(dbg_state), 32'd0);
    @(negedge CLK);
    ihit = 1'b0;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_state", WORD_W'(dbg_state), 32'd0);
    check("post_rst_dmemREN", WORD_W'(mif.dmemREN), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
